// File: rtl/uart_pkg.sv
// Shared UART baud constants: preset baud table, custom-select code and divisor math.
// The divisor functions run only at elaboration time.
package uart_pkg;

   localparam logic [2:0]  SEL_CUSTOM  = 3'd7;
   localparam int unsigned NUM_PRESETS = 32'd7;

   localparam int unsigned BAUD_TABLE [NUM_PRESETS] = '{
      32'd9600, 32'd19200, 32'd38400, 32'd57600, 32'd115200, 32'd230400, 32'd921600
   };

   // Remainder of clk/(ovs*baud) rounded to frac_w bits; may round up to 2^frac_w.
   function automatic longint unsigned frac_round(input longint unsigned clk_hz,
                                                  input int unsigned ovs,
                                                  input int unsigned baud,
                                                  input int unsigned frac_w);
      longint unsigned den;
      den = 64'(ovs) * 64'(baud);
      return (((clk_hz % den) << frac_w) + (den / 64'd2)) / den;
   endfunction

   function automatic longint unsigned calc_div_int(input longint unsigned clk_hz,
                                                    input int unsigned ovs,
                                                    input int unsigned baud,
                                                    input int unsigned frac_w);
      longint unsigned q;
      q = clk_hz / (64'(ovs) * 64'(baud));
      if (frac_round(clk_hz, ovs, baud, frac_w) >= (64'd1 << frac_w)) q = q + 64'd1;
      else q = q;
      return q;
   endfunction

   function automatic longint unsigned calc_div_frac(input longint unsigned clk_hz,
                                                     input int unsigned ovs,
                                                     input int unsigned baud,
                                                     input int unsigned frac_w);
      longint unsigned f;
      f = frac_round(clk_hz, ovs, baud, frac_w);
      if (f >= (64'd1 << frac_w)) f = 64'd0;
      else f = f;
      return f;
   endfunction

endpackage

// File: rtl/uart_frac_div.sv
// Oversample period divider: down-counter with optional fractional accumulator.
// Accumulator exists only when UART_BAUDGEN_FRAC_EN is defined.
module uart_frac_div
   import uart_pkg::*;
#(
   parameter int unsigned DIV_W  = 32'd16,
   parameter int unsigned FRAC_W = 32'd4
) (
   input  logic              clkin,
   input  logic              rst_n,
   input  logic              en,
   input  logic              resync,
   input  logic [DIV_W-1:0]  div_int,
   input  logic [FRAC_W-1:0] div_frac,
   output logic              fire
);
   localparam logic [DIV_W-1:0] ONE_C = {{(DIV_W-1){1'b0}}, 1'b1};
   localparam logic [DIV_W-1:0] TWO_C = {{(DIV_W-2){1'b0}}, 2'b10};

   logic [DIV_W-1:0] cnt_r;
   logic             run_r;
   logic             carry_s;

   assign fire = en & run_r & ~resync & (cnt_r == {DIV_W{1'b0}});

`ifdef UART_BAUDGEN_FRAC_EN
   logic [FRAC_W-1:0] acc_r;
   logic [FRAC_W:0]   sum_s;

   assign sum_s   = {1'b0, acc_r} + {1'b0, div_frac};
   assign carry_s = sum_s[FRAC_W];

   // Fractional accumulator, stepped once per oversample tick.
   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n)              acc_r <= {FRAC_W{1'b0}};
      else if (!en || resync)  acc_r <= {FRAC_W{1'b0}};
      else if (fire)           acc_r <= sum_s[FRAC_W-1:0];
      else                     acc_r <= acc_r;
   end
`else
   logic frac_unused_s;
   assign frac_unused_s = ^div_frac;
   assign carry_s       = 1'b0;
`endif

   // Period counter; the first enabled cycle is consumed by the start load, hence div_int-2.
   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {DIV_W{1'b0}};
         run_r <= 1'b0;
      end else if (!en) begin
         cnt_r <= {DIV_W{1'b0}};
         run_r <= 1'b0;
      end else if (resync) begin
         cnt_r <= div_int - ONE_C;
         run_r <= 1'b1;
      end else if (!run_r) begin
         cnt_r <= div_int - TWO_C;
         run_r <= 1'b1;
      end else if (cnt_r == {DIV_W{1'b0}}) begin
         cnt_r <= div_int - ONE_C + {{(DIV_W-1){1'b0}}, carry_s};
         run_r <= 1'b1;
      end else begin
         cnt_r <= cnt_r - ONE_C;
         run_r <= 1'b1;
      end
   end

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud generator: oversample tick, bit tick and bit phase with latched config.
// Fractional division is compiled in only when UART_BAUDGEN_FRAC_EN is defined.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ = 32'd100_000_000,
   parameter int unsigned OVS    = 32'd16,
   parameter int unsigned DIV_W  = 32'd16,
   parameter int unsigned FRAC_W = 32'd4
) (
   input  logic                   clkin,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic [2:0]             baud_sel,
   input  logic [DIV_W-1:0]       div_int,
   input  logic [FRAC_W-1:0]      div_frac,
   input  logic                   resync,
   output logic                   os_tick,
   output logic                   baud_tick,
   output logic [$clog2(OVS)-1:0] os_phase
);
   localparam int unsigned      PH_W    = $clog2(OVS);
   localparam logic [PH_W-1:0]  PH_LAST = PH_W'(OVS - 32'd1);
   localparam logic [PH_W-1:0]  PH_HALF = PH_W'(OVS / 32'd2);
   localparam logic [DIV_W-1:0] DIV_MIN = {{(DIV_W-2){1'b0}}, 2'b10};

   logic [2:0]        sel_r, sel_nx_s;
   logic [DIV_W-1:0]  div_int_r, div_int_nx_s, raw_int_s, eff_int_s;
   logic [FRAC_W-1:0] eff_frac_s;
   logic [DIV_W-1:0]  preset_int_s [8];
   logic [PH_W-1:0]   phase_r;
   logic              os_tick_r, baud_tick_r;
   logic              fire_s, bit_end_s, latch_s;

   for (genvar g = 0; g < NUM_PRESETS; g++) begin : g_preset_int
      localparam longint unsigned P_INT = calc_div_int(64'(CLK_HZ), OVS, BAUD_TABLE[g], FRAC_W);
      assign preset_int_s[g] = P_INT[DIV_W-1:0];
   end
   assign preset_int_s[SEL_CUSTOM] = {DIV_W{1'b0}};

   // Config only moves while idle or on a bit boundary, so a running bit keeps its period.
   assign bit_end_s = fire_s & (phase_r == PH_LAST);
   assign latch_s   = ~en | bit_end_s;

   // Effective integer divisor, seen by the counter in the same cycle it is latched.
   always_comb begin
      sel_nx_s     = sel_r;
      div_int_nx_s = div_int_r;
      if (latch_s) begin
         sel_nx_s     = baud_sel;
         div_int_nx_s = div_int;
      end else begin
         sel_nx_s     = sel_r;
         div_int_nx_s = div_int_r;
      end
      if (sel_nx_s == SEL_CUSTOM) raw_int_s = div_int_nx_s;
      else                        raw_int_s = preset_int_s[sel_nx_s];
      if (raw_int_s < DIV_MIN)    eff_int_s = DIV_MIN;
      else                        eff_int_s = raw_int_s;
   end

   // Active integer config register.
   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         sel_r     <= 3'd0;
         div_int_r <= {DIV_W{1'b0}};
      end else begin
         sel_r     <= sel_nx_s;
         div_int_r <= div_int_nx_s;
      end
   end

`ifdef UART_BAUDGEN_FRAC_EN
   logic [FRAC_W-1:0] div_frac_r, div_frac_nx_s;
   logic [FRAC_W-1:0] preset_frac_s [8];

   for (genvar g = 0; g < NUM_PRESETS; g++) begin : g_preset_frac
      localparam longint unsigned P_FRAC = calc_div_frac(64'(CLK_HZ), OVS, BAUD_TABLE[g], FRAC_W);
      assign preset_frac_s[g] = P_FRAC[FRAC_W-1:0];
   end
   assign preset_frac_s[SEL_CUSTOM] = {FRAC_W{1'b0}};

   // Effective fractional divisor.
   always_comb begin
      div_frac_nx_s = div_frac_r;
      if (latch_s) div_frac_nx_s = div_frac;
      else         div_frac_nx_s = div_frac_r;
      if (sel_nx_s == SEL_CUSTOM) eff_frac_s = div_frac_nx_s;
      else                        eff_frac_s = preset_frac_s[sel_nx_s];
   end

   // Active fractional config register.
   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) div_frac_r <= {FRAC_W{1'b0}};
      else        div_frac_r <= div_frac_nx_s;
   end
`else
   logic frac_unused_s;
   assign frac_unused_s = ^div_frac;
   assign eff_frac_s    = {FRAC_W{1'b0}};
`endif

   uart_frac_div #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_frac_div (
      .clkin    (clkin),
      .rst_n    (rst_n),
      .en       (en),
      .resync   (resync),
      .div_int  (eff_int_s),
      .div_frac (eff_frac_s),
      .fire     (fire_s)
   );

   // Bit phase and registered tick outputs; resync drops the coincident tick.
   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         phase_r     <= {PH_W{1'b0}};
         os_tick_r   <= 1'b0;
         baud_tick_r <= 1'b0;
      end else if (!en) begin
         phase_r     <= {PH_W{1'b0}};
         os_tick_r   <= 1'b0;
         baud_tick_r <= 1'b0;
      end else if (resync) begin
         phase_r     <= PH_HALF;
         os_tick_r   <= 1'b0;
         baud_tick_r <= 1'b0;
      end else begin
         os_tick_r   <= fire_s;
         baud_tick_r <= bit_end_s;
         if (fire_s) phase_r <= phase_r + {{(PH_W-1){1'b0}}, 1'b1};
         else        phase_r <= phase_r;
      end
   end

   assign os_tick   = os_tick_r;
   assign baud_tick = baud_tick_r;
   assign os_phase  = phase_r;

endmodule
